// File: rtl/pkt_a2f_mux.sv
// ---------------------------------------------------------------------------
// pkt_a2f_mux
//   Packetises two sources onto one FTDI-style read port. Each packet is one
//   header word followed by a fixed number of payload words. Payload comes
//   either from the I/Q sample FIFO (unpacked into 12-bit Q/I lanes) or from
//   the CPU block buffer. A CPU block posted by software is signalled by a
//   free-running block counter; this module keeps its own count of blocks
//   already sent and serves the CPU whenever the two differ.
//
// Ports
//   clk_i          : only clock
//   reset          : asynchronous active-high reset
//   fifo_data_i    : packed I/Q pair, I in the low half
//   fifo_empty_i   : sample FIFO empty
//   fifo_enough_i  : sample FIFO holds at least one full packet
//   fifo_re_o      : sample FIFO pop
//   cpu_data_i     : CPU block data word
//   cpu_empty_i    : CPU buffer empty
//   cpu_blkcnt_i   : free-running count of CPU blocks posted
//   cpu_re_o       : CPU buffer pop
//   re_i           : read strobe, one word per clock while high
//   data_o         : output word (header, payload, or 0 when idle)
//   empty_o        : no word available at data_o
//   enough_o       : a packet is ready to start
//   seq_o          : current packet sequence number
//   underrun_o     : sticky, a read hit an empty source mid-packet
//   busy_o         : a packet is in progress
//
// Header word: [31:28] source tag (A = FIFO, C = CPU), [27:16] sequence,
//              [15:0] payload words minus one.
// ---------------------------------------------------------------------------
module pkt_a2f_mux #(
  parameter int FT_DATA_WIDTH    = 32,
  parameter int IQ_PAIR_WIDTH    = 24,
  parameter int QSTART_BIT_INDEX = 16,
  parameter int FIFO_PKT_WORDS   = 4096,
  parameter int CPU_PKT_WORDS    = 256,
  parameter int BLKCNT_WIDTH     = 4
) (
  input  logic                     clk_i,
  input  logic                     reset,

  input  logic [IQ_PAIR_WIDTH-1:0] fifo_data_i,
  input  logic                     fifo_empty_i,
  input  logic                     fifo_enough_i,
  output logic                     fifo_re_o,

  input  logic [FT_DATA_WIDTH-1:0] cpu_data_i,
  input  logic                     cpu_empty_i,
  input  logic [BLKCNT_WIDTH-1:0]  cpu_blkcnt_i,
  output logic                     cpu_re_o,

  input  logic                     re_i,
  output logic [FT_DATA_WIDTH-1:0] data_o,
  output logic                     empty_o,
  output logic                     enough_o,

  output logic [11:0]              seq_o,
  output logic                     underrun_o,
  output logic                     busy_o
);

  // State table
  //   state      | meaning
  //   S_IDLE     | no packet; pick the next source (CPU first)
  //   S_HDR_FIFO | presenting the FIFO packet header
  //   S_FIFO     | streaming FIFO I/Q payload
  //   S_HDR_CPU  | presenting the CPU packet header
  //   S_CPU      | streaming CPU block payload

  localparam int HALF_W = IQ_PAIR_WIDTH / 2;
  localparam int CNT_W  = 16;

  localparam logic [CNT_W-1:0] FIFO_LAST = CNT_W'(FIFO_PKT_WORDS - 1);
  localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_PKT_WORDS - 1);

  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_HDR_FIFO = 5'b00010,
    S_FIFO     = 5'b00100,
    S_HDR_CPU  = 5'b01000,
    S_CPU      = 5'b10000
  } state_e;

  state_e                   state_q;
  logic [11:0]              seq_q;
  logic [BLKCNT_WIDTH-1:0]  blks_done_q;
  logic [FT_DATA_WIDTH-1:0] hdr_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     underrun_q;

  logic                     cpu_pending;
  logic                     fifo_pop;
  logic                     cpu_pop;
  logic [FT_DATA_WIDTH-1:0] iq_word;

  function automatic logic [FT_DATA_WIDTH-1:0] make_hdr(
    input logic [3:0]       tag,
    input logic [11:0]      seq,
    input logic [CNT_W-1:0] last
  );
    logic [FT_DATA_WIDTH-1:0] h;
    h        = '0;
    h[31:0]  = {tag, seq, last};
    return h;
  endfunction

  // Unequal counts mean software has posted blocks not yet sent; the
  // comparison also covers counter wrap without any extra logic.
  assign cpu_pending = (blks_done_q != cpu_blkcnt_i);

  assign fifo_pop = re_i & (state_q == S_FIFO) & ~fifo_empty_i;
  assign cpu_pop  = re_i & (state_q == S_CPU)  & ~cpu_empty_i;

  // Q goes to the upper lane, I to the lowest bits; everything else stays 0.
  always_comb begin
    iq_word                                = '0;
    iq_word[QSTART_BIT_INDEX +: HALF_W]    = fifo_data_i[IQ_PAIR_WIDTH-1 -: HALF_W];
    iq_word[HALF_W-1:0]                    = fifo_data_i[HALF_W-1:0];
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      seq_q       <= '0;
      blks_done_q <= '0;
      hdr_q       <= '0;
      cnt_q       <= '0;
      underrun_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cpu_pending) begin
            // One block per IDLE visit; further pending blocks wait here.
            blks_done_q <= blks_done_q + BLKCNT_WIDTH'(1);
            hdr_q       <= make_hdr(4'hC, seq_q, CPU_LAST);
            state_q     <= S_HDR_CPU;
          end else if (fifo_enough_i) begin
            hdr_q       <= make_hdr(4'hA, seq_q, FIFO_LAST);
            state_q     <= S_HDR_FIFO;
          end
        end

        S_HDR_FIFO: begin
          if (re_i) begin
            seq_q   <= seq_q + 12'd1;
            state_q <= S_FIFO;
          end
        end

        S_HDR_CPU: begin
          if (re_i) begin
            seq_q   <= seq_q + 12'd1;
            state_q <= S_CPU;
          end
        end

        S_FIFO: begin
          if (fifo_pop) begin
            if (cnt_q == FIFO_LAST) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end else if (re_i) begin
            // Read with the source empty: word is not consumed, stay put.
            underrun_q <= 1'b1;
          end
        end

        S_CPU: begin
          if (cpu_pop) begin
            if (cnt_q == CPU_LAST) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end else if (re_i) begin
            underrun_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    data_o  = '0;
    empty_o = 1'b1;
    unique case (state_q)
      S_HDR_FIFO, S_HDR_CPU: begin
        data_o  = hdr_q;
        empty_o = 1'b0;
      end
      S_FIFO: begin
        data_o  = iq_word;
        empty_o = fifo_empty_i;
      end
      S_CPU: begin
        data_o  = cpu_data_i;
        empty_o = cpu_empty_i;
      end
      default: begin
        data_o  = '0;
        empty_o = 1'b1;
      end
    endcase
  end

  assign fifo_re_o  = fifo_pop;
  assign cpu_re_o   = cpu_pop;
  assign enough_o   = fifo_enough_i | cpu_pending;
  assign seq_o      = seq_q;
  assign underrun_o = underrun_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_pkt_a2f_mux.sv
// ---------------------------------------------------------------------------
// tb_pkt_a2f_mux
//   Directed bench for pkt_a2f_mux. A second, small-packet instance is used
//   to walk the 12-bit sequence number through its wrap in few cycles.
// ---------------------------------------------------------------------------
module tb_pkt_a2f_mux;

  logic        clk_i = 1'b0;
  logic        reset = 1'b1;
  always #5 clk_i = ~clk_i;

  // main instance
  logic [23:0] fifo_data_i   = 24'hABC123;
  logic        fifo_empty_i  = 1'b0;
  logic        fifo_enough_i = 1'b0;
  logic        fifo_re_o;
  logic [31:0] cpu_data_i    = 32'h1234_5678;
  logic        cpu_empty_i   = 1'b0;
  logic [3:0]  cpu_blkcnt_i  = 4'd0;
  logic        cpu_re_o;
  logic        re_i          = 1'b0;
  logic [31:0] data_o;
  logic        empty_o;
  logic        enough_o;
  logic [11:0] seq_o;
  logic        underrun_o;
  logic        busy_o;

  // small-packet instance
  logic        fifo_enough_s = 1'b0;
  logic        re_s          = 1'b0;
  logic        fifo_re_s;
  logic        cpu_re_s;
  logic [31:0] data_s;
  logic        empty_s;
  logic        enough_s;
  logic [11:0] seq_s;
  logic        underrun_s;
  logic        busy_s;

  localparam logic [31:0] IQ_WORD = 32'h0ABC_0123;

  pkt_a2f_mux dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .fifo_data_i  (fifo_data_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_enough_i(fifo_enough_i),
    .fifo_re_o    (fifo_re_o),
    .cpu_data_i   (cpu_data_i),
    .cpu_empty_i  (cpu_empty_i),
    .cpu_blkcnt_i (cpu_blkcnt_i),
    .cpu_re_o     (cpu_re_o),
    .re_i         (re_i),
    .data_o       (data_o),
    .empty_o      (empty_o),
    .enough_o     (enough_o),
    .seq_o        (seq_o),
    .underrun_o   (underrun_o),
    .busy_o       (busy_o)
  );

  pkt_a2f_mux #(.FIFO_PKT_WORDS(2), .CPU_PKT_WORDS(1)) dut_s (
    .clk_i        (clk_i),
    .reset        (reset),
    .fifo_data_i  (24'hABC123),
    .fifo_empty_i (1'b0),
    .fifo_enough_i(fifo_enough_s),
    .fifo_re_o    (fifo_re_s),
    .cpu_data_i   (32'h0),
    .cpu_empty_i  (1'b1),
    .cpu_blkcnt_i (4'd0),
    .cpu_re_o     (cpu_re_s),
    .re_i         (re_s),
    .data_o       (data_s),
    .empty_o      (empty_s),
    .enough_o     (enough_s),
    .seq_o        (seq_s),
    .underrun_o   (underrun_s),
    .busy_o       (busy_s)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fifo_pops = 0;
  int cpu_pops  = 0;

  always @(posedge clk_i) begin
    if (fifo_re_o) fifo_pops++;
    if (cpu_re_o)  cpu_pops++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    re_i  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Expects the DUT in IDLE with a source ready; runs one whole packet.
  task automatic run_packet(input string tag, input logic [31:0] hdr_exp,
                            input bit is_cpu, input logic [31:0] word_exp,
                            input int pops_exp);
    int n;
    step();
    chk({tag, "_hdr"}, data_o, hdr_exp);
    chk({tag, "_hdr_empty"}, {31'd0, empty_o}, 32'd0);
    fifo_pops = 0;
    cpu_pops  = 0;
    re_i = 1'b1;
    #1;
    chk({tag, "_hdr_nopop"}, {30'd0, fifo_re_o, cpu_re_o}, 32'd0);
    step();
    chk({tag, "_word0"}, data_o, word_exp);
    n = 0;
    while (busy_o && n < 5000) begin
      step();
      n++;
    end
    re_i = 1'b0;
    chk({tag, "_done"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_pops"}, is_cpu ? cpu_pops : fifo_pops, pops_exp);
    chk({tag, "_other_pops"}, is_cpu ? fifo_pops : cpu_pops, 32'd0);
  endtask

  initial begin
    int n;
    int n_hdr;
    int seq_err;
    logic [31:0] hdr_4095;
    logic [31:0] hdr_4096;
    logic [11:0] seq_at_4096;

    // reset state
    step();
    step();
    chk("rst_busy",     {31'd0, busy_o}, 32'd0);
    chk("rst_empty",    {31'd0, empty_o}, 32'd1);
    chk("rst_data",     data_o, 32'd0);
    chk("rst_seq",      {20'd0, seq_o}, 32'd0);
    chk("rst_underrun", {31'd0, underrun_o}, 32'd0);
    chk("rst_pops",     {30'd0, fifo_re_o, cpu_re_o}, 32'd0);
    chk("rst_enough",   {31'd0, enough_o}, 32'd0);
    reset = 1'b0;

    // single FIFO packet
    fifo_enough_i = 1'b1;
    #1;
    chk("fifo_enough", {31'd0, enough_o}, 32'd1);
    run_packet("fifo0", 32'hA000_0FFF, 1'b0, IQ_WORD, 4096);
    fifo_enough_i = 1'b0;
    chk("fifo0_seq", {20'd0, seq_o}, 32'd1);
    step();
    chk("idle_data",     data_o, 32'd0);
    chk("idle_empty",    {31'd0, empty_o}, 32'd1);
    chk("idle_busy",     {31'd0, busy_o}, 32'd0);
    chk("idle_underrun", {31'd0, underrun_o}, 32'd0);

    // CPU priority: two blocks and FIFO ready together
    do_reset();
    cpu_blkcnt_i  = 4'd2;
    fifo_enough_i = 1'b1;
    #1;
    chk("prio_enough", {31'd0, enough_o}, 32'd1);
    run_packet("cpu0", 32'hC000_00FF, 1'b1, 32'h1234_5678, 256);
    run_packet("cpu1", 32'hC001_00FF, 1'b1, 32'h1234_5678, 256);
    run_packet("fifo2", 32'hA002_0FFF, 1'b0, IQ_WORD, 4096);
    fifo_enough_i = 1'b0;
    step();
    chk("prio_idle",   {31'd0, busy_o}, 32'd0);
    chk("prio_enough_clr", {31'd0, enough_o}, 32'd0);

    // underrun at word 100
    fifo_enough_i = 1'b1;
    step();
    chk("ur_hdr", data_o, 32'hA003_0FFF);
    fifo_enough_i = 1'b0;
    fifo_pops = 0;
    re_i = 1'b1;
    step();
    n = 0;
    while (fifo_pops < 100 && n < 5000) begin
      step();
      n++;
    end
    chk("ur_pre_pops", fifo_pops, 32'd100);
    chk("ur_pre_flag", {31'd0, underrun_o}, 32'd0);
    fifo_empty_i = 1'b1;
    #1;
    chk("ur_nopop", {31'd0, fifo_re_o}, 32'd0);
    chk("ur_empty", {31'd0, empty_o}, 32'd1);
    repeat (3) step();
    chk("ur_hold_pops", fifo_pops, 32'd100);
    chk("ur_flag",      {31'd0, underrun_o}, 32'd1);
    chk("ur_busy",      {31'd0, busy_o}, 32'd1);
    fifo_empty_i = 1'b0;
    n = 0;
    while (busy_o && n < 5000) begin
      step();
      n++;
    end
    re_i = 1'b0;
    chk("ur_done",      {31'd0, busy_o}, 32'd0);
    chk("ur_total",     fifo_pops, 32'd4096);
    chk("ur_sticky",    {31'd0, underrun_o}, 32'd1);

    // reset at FIFO word 2000
    fifo_enough_i = 1'b1;
    step();
    chk("mr_hdr", data_o, 32'hA004_0FFF);
    fifo_enough_i = 1'b0;
    fifo_pops = 0;
    re_i = 1'b1;
    step();
    n = 0;
    while (fifo_pops < 2000 && n < 5000) begin
      step();
      n++;
    end
    cpu_blkcnt_i = 4'd0;
    reset = 1'b1;
    #1;
    chk("mr_busy",     {31'd0, busy_o}, 32'd0);
    chk("mr_nopop",    {30'd0, fifo_re_o, cpu_re_o}, 32'd0);
    chk("mr_seq",      {20'd0, seq_o}, 32'd0);
    chk("mr_data",     data_o, 32'd0);
    chk("mr_empty",    {31'd0, empty_o}, 32'd1);
    chk("mr_underrun", {31'd0, underrun_o}, 32'd0);
    step();
    step();
    chk("mr_pops", fifo_pops, 32'd2000);
    reset = 1'b0;
    re_i  = 1'b0;
    fifo_enough_i = 1'b1;
    run_packet("mr_next", 32'hA000_0FFF, 1'b0, IQ_WORD, 4096);
    fifo_enough_i = 1'b0;

    // block counter wrap 15 -> 0
    do_reset();
    cpu_blkcnt_i = 4'd15;
    for (int i = 0; i < 15; i++)
      run_packet($sformatf("blk%0d", i), {4'hC, 12'(i), 16'h00FF}, 1'b1, 32'h1234_5678, 256);
    step();
    chk("blk15_idle",   {31'd0, busy_o}, 32'd0);
    chk("blk15_enough", {31'd0, enough_o}, 32'd0);
    cpu_blkcnt_i = 4'd0;
    #1;
    chk("blkwrap_enough", {31'd0, enough_o}, 32'd1);
    run_packet("blkwrap", 32'hC00F_00FF, 1'b1, 32'h1234_5678, 256);
    step();
    step();
    chk("blkwrap_idle",   {31'd0, busy_o}, 32'd0);
    chk("blkwrap_caught", {31'd0, enough_o}, 32'd0);

    // sequence wrap on the small-packet instance
    fifo_enough_s = 1'b1;
    re_s          = 1'b1;
    n_hdr   = 0;
    seq_err = 0;
    hdr_4095 = '0;
    hdr_4096 = '0;
    seq_at_4096 = 12'hFFF;
    n = 0;
    while (n_hdr < 4097 && n < 20000) begin
      step();
      n++;
      if (busy_s && !fifo_re_s) begin
        if (data_s[27:16] != 12'(n_hdr)) seq_err++;
        if (n_hdr == 4095) hdr_4095 = data_s;
        if (n_hdr == 4096) begin
          hdr_4096    = data_s;
          seq_at_4096 = seq_s;
        end
        n_hdr++;
      end
    end
    fifo_enough_s = 1'b0;
    re_s          = 1'b0;
    chk("seqwrap_count",  n_hdr, 32'd4097);
    chk("seqwrap_errors", seq_err, 32'd0);
    chk("seqwrap_last",   hdr_4095, 32'hAFFF_0001);
    chk("seqwrap_hdr",    hdr_4096, 32'hA000_0001);
    chk("seqwrap_seq",    {20'd0, seq_at_4096}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
